// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared receiver state encoding, data-length limits and vote helpers
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRKWAIT
    } rx_state_e;

    localparam logic [3:0] DLEN_MIN = 4'd5;
    localparam logic [3:0] DLEN_MAX = 4'd9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [3:0] clamp_dlen(input logic [3:0] d);
        if (d < DLEN_MIN) begin
            return DLEN_MIN;
        end
        if (d > DLEN_MAX) begin
            return DLEN_MAX;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - Free-running oversample tick divider, one tick every ckdiv+1 clocks
module uart_baud_tick #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic [DIV_W-1:0] ckdiv,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - DIV_W'(1);
        if (tick) begin
            cnt_d = ckdiv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ckdiv;
        end else if (!clr_n) begin
            cnt_q <= ckdiv;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - Oversampling UART receiver: majority vote, 5..9 data bits, parity,
// framing/overrun/break detection and idle-line timeout feeding the receive FIFO
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DIV_W    = 24,
    parameter int OVS      = 16,
    parameter int SYNC_STG = 2,
    parameter int TO_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic [DIV_W-1:0] ckdiv,
    input  logic [3:0]       dlen,
    input  logic             par_en,
    input  logic             par_odd,
    input  logic             stop2,
    input  logic [TO_W-1:0]  totime,
    output logic             timeout,
    output logic             rf_write,
    output logic [8:0]       rf_wbyte,
    input  logic             rf_full,
    output logic             perr,
    output logic             ferr,
    output logic             overrun,
    output logic             brk,
    input  logic             uart_rxd
);

    localparam int SC_W = $clog2(OVS);
    localparam logic [SC_W-1:0] SC_V0   = SC_W'(OVS / 2 - 1);
    localparam logic [SC_W-1:0] SC_V1   = SC_W'(OVS / 2);
    localparam logic [SC_W-1:0] SC_V2   = SC_W'(OVS / 2 + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVS - 1);

    logic                tick;
    logic [SYNC_STG-1:0] sync_q;
    logic                rxs;
    logic                rxs_prev_q;
    logic                start_edge;

    logic [SC_W-1:0]     sc_q, sc_d;
    logic                va_q, vb_q;
    logic                vote_pt;
    logic                vote;
    logic [3:0]          dlen_eff;

    rx_state_e           state_q, state_d;
    logic [3:0]          nbit_q, nbit_d;
    logic [8:0]          shreg_q, shreg_d;
    logic                perr_pend_q, perr_pend_d;
    logic                ferr_pend_q, ferr_pend_d;
    logic                stop_idx_q, stop_idx_d;
    logic                stop1_q, stop1_d;
    logic                par_bit_q, par_bit_d;

    logic                ferr_now;
    logic                stop1_now;
    logic                is_break;
    logic                frame_end;

    logic                rf_write_q, rf_write_d;
    logic [8:0]          rf_wbyte_q, rf_wbyte_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                overrun_q, overrun_d;
    logic                brk_q, brk_d;

    logic                armed_q, armed_d;
    logic [SC_W-1:0]     to_sub_q, to_sub_d;
    logic [TO_W-1:0]     to_bits_q, to_bits_d;
    logic                timeout_q, timeout_d;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_n (clr_n),
        .ckdiv (ckdiv),
        .tick  (tick)
    );

    assign rxs        = sync_q[SYNC_STG-1];
    assign start_edge = (state_q == IDLE) && rxs_prev_q && !rxs;
    assign vote_pt    = tick && (sc_q == SC_V2);
    assign vote       = maj3(va_q, vb_q, rxs);
    assign dlen_eff   = clamp_dlen(dlen);

    always_comb begin
        sc_d = sc_q;
        if (start_edge) begin
            sc_d = '0;
        end else if (tick) begin
            sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        nbit_d      = nbit_q;
        shreg_d     = shreg_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        stop_idx_d  = stop_idx_q;
        stop1_d     = stop1_q;
        par_bit_d   = par_bit_q;
        rf_write_d  = 1'b0;
        rf_wbyte_d  = rf_wbyte_q;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        overrun_d   = 1'b0;
        brk_d       = 1'b0;
        frame_end   = 1'b0;
        ferr_now    = ferr_pend_q | ~vote;
        stop1_now   = stop_idx_q ? stop1_q : vote;
        is_break    = (shreg_q == '0) && !(par_en && par_bit_q) && !stop1_now;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (vote_pt) begin
                    if (vote) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = DATA;
                        nbit_d      = '0;
                        shreg_d     = '0;
                        perr_pend_d = 1'b0;
                        ferr_pend_d = 1'b0;
                        stop_idx_d  = 1'b0;
                        par_bit_d   = 1'b0;
                    end
                end
            end
            DATA: begin
                if (vote_pt) begin
                    shreg_d[nbit_q] = vote;
                    if (nbit_q == dlen_eff - 4'd1) begin
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        nbit_d = nbit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (vote_pt) begin
                    par_bit_d   = vote;
                    perr_pend_d = vote ^ (^shreg_q) ^ par_odd;
                    state_d     = STOP;
                end
            end
            STOP: begin
                // The frame resolves at the last stop vote, mid-bit, so a following start edge is not missed.
                if (vote_pt) begin
                    if (stop2 && !stop_idx_q) begin
                        stop_idx_d  = 1'b1;
                        stop1_d     = vote;
                        ferr_pend_d = ferr_now;
                    end else if (is_break) begin
                        brk_d   = 1'b1;
                        state_d = BRKWAIT;
                    end else begin
                        frame_end = 1'b1;
                        state_d   = IDLE;
                        if (rf_full) begin
                            overrun_d = 1'b1;
                        end else begin
                            rf_write_d = 1'b1;
                            rf_wbyte_d = shreg_q;
                            perr_d     = perr_pend_q;
                            ferr_d     = ferr_now;
                        end
                    end
                end
            end
            BRKWAIT: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A start edge outranks a terminal count in the same cycle.
    always_comb begin
        armed_d   = armed_q;
        to_sub_d  = to_sub_q;
        to_bits_d = to_bits_q;
        timeout_d = 1'b0;
        if (start_edge) begin
            to_sub_d  = '0;
            to_bits_d = '0;
        end else if (frame_end) begin
            armed_d   = 1'b1;
            to_sub_d  = '0;
            to_bits_d = '0;
        end else if ((state_q == IDLE) && armed_q && (totime != '0) && tick) begin
            if (to_sub_q == SC_LAST) begin
                to_sub_d = '0;
                if ((to_bits_q + TO_W'(1)) == totime) begin
                    timeout_d = 1'b1;
                    armed_d   = 1'b0;
                    to_bits_d = '0;
                end else begin
                    to_bits_d = to_bits_q + TO_W'(1);
                end
            end else begin
                to_sub_d = to_sub_q + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            rxs_prev_q  <= 1'b1;
            sc_q        <= '0;
            va_q        <= 1'b1;
            vb_q        <= 1'b1;
            state_q     <= IDLE;
            nbit_q      <= '0;
            shreg_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            stop_idx_q  <= 1'b0;
            stop1_q     <= 1'b1;
            par_bit_q   <= 1'b0;
            rf_write_q  <= 1'b0;
            rf_wbyte_q  <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_q   <= 1'b0;
            brk_q       <= 1'b0;
            armed_q     <= 1'b0;
            to_sub_q    <= '0;
            to_bits_q   <= '0;
            timeout_q   <= 1'b0;
        end else if (!clr_n) begin
            sync_q      <= '1;
            rxs_prev_q  <= 1'b1;
            sc_q        <= '0;
            va_q        <= 1'b1;
            vb_q        <= 1'b1;
            state_q     <= IDLE;
            nbit_q      <= '0;
            shreg_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            stop_idx_q  <= 1'b0;
            stop1_q     <= 1'b1;
            par_bit_q   <= 1'b0;
            rf_write_q  <= 1'b0;
            rf_wbyte_q  <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_q   <= 1'b0;
            brk_q       <= 1'b0;
            armed_q     <= 1'b0;
            to_sub_q    <= '0;
            to_bits_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STG-2:0], uart_rxd};
            rxs_prev_q  <= rxs;
            sc_q        <= sc_d;
            if (tick && (sc_q == SC_V0)) begin
                va_q <= rxs;
            end
            if (tick && (sc_q == SC_V1)) begin
                vb_q <= rxs;
            end
            state_q     <= state_d;
            nbit_q      <= nbit_d;
            shreg_q     <= shreg_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            stop_idx_q  <= stop_idx_d;
            stop1_q     <= stop1_d;
            par_bit_q   <= par_bit_d;
            rf_write_q  <= rf_write_d;
            rf_wbyte_q  <= rf_wbyte_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            overrun_q   <= overrun_d;
            brk_q       <= brk_d;
            armed_q     <= armed_d;
            to_sub_q    <= to_sub_d;
            to_bits_q   <= to_bits_d;
            timeout_q   <= timeout_d;
        end
    end

    assign rf_write = rf_write_q;
    assign rf_wbyte = rf_wbyte_q;
    assign perr     = perr_q;
    assign ferr     = ferr_q;
    assign overrun  = overrun_q;
    assign brk      = brk_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - Directed and randomised frame bench for uart_rx_os with a frame-level reference model
module tb_uart_rx_os;

    localparam int DIV_W    = 24;
    localparam int OVS      = 16;
    localparam int SYNC_STG = 2;
    localparam int TO_W     = 8;
    localparam int K_WR     = 0;
    localparam int K_BRK    = 1;
    localparam int K_OVR    = 2;
    localparam int K_TO     = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr_n;
    logic [DIV_W-1:0] ckdiv;
    logic [3:0]       dlen;
    logic             par_en;
    logic             par_odd;
    logic             stop2;
    logic [TO_W-1:0]  totime;
    logic             timeout;
    logic             rf_write;
    logic [8:0]       rf_wbyte;
    logic             rf_full;
    logic             perr;
    logic             ferr;
    logic             overrun;
    logic             brk;
    logic             uart_rxd;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    typedef struct {
        int          kind;
        logic [8:0]  data;
        logic        pe;
        logic        fe;
        int unsigned t;
    } ev_t;

    ev_t evq[$];

    uart_rx_os #(
        .DIV_W    (DIV_W),
        .OVS      (OVS),
        .SYNC_STG (SYNC_STG),
        .TO_W     (TO_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_n    (clr_n),
        .ckdiv    (ckdiv),
        .dlen     (dlen),
        .par_en   (par_en),
        .par_odd  (par_odd),
        .stop2    (stop2),
        .totime   (totime),
        .timeout  (timeout),
        .rf_write (rf_write),
        .rf_wbyte (rf_wbyte),
        .rf_full  (rf_full),
        .perr     (perr),
        .ferr     (ferr),
        .overrun  (overrun),
        .brk      (brk),
        .uart_rxd (uart_rxd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input int k);
        ev_t e;
        e.kind = k;
        e.data = rf_wbyte;
        e.pe   = perr;
        e.fe   = ferr;
        e.t    = cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_write) evq.push_back(mk_ev(K_WR));
            if (brk)      evq.push_back(mk_ev(K_BRK));
            if (overrun)  evq.push_back(mk_ev(K_OVR));
            if (timeout)  evq.push_back(mk_ev(K_TO));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_clks();
        return (int'(ckdiv) + 1) * OVS;
    endfunction

    task automatic send_bit(input logic v);
        uart_rxd = v;
        repeat (bit_clks()) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        uart_rxd = 1'b1;
        repeat (n * bit_clks()) @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] d, input int n, input logic pe, input logic pb,
                              input logic s1, input logic st2, input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(d[i]);
        if (pe) send_bit(pb);
        send_bit(s1);
        if (st2) send_bit(s2);
        uart_rxd = 1'b1;
    endtask

    task automatic expect_ev(input string tag, input int kind, input logic [8:0] d,
                             input logic pe, input logic fe);
        ev_t e;
        chk({tag, "_count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk({tag, "_kind"}, e.kind, kind);
            if (kind == K_WR) begin
                chk({tag, "_data"}, e.data, d);
                chk({tag, "_perr"}, e.pe, pe);
                chk({tag, "_ferr"}, e.fe, fe);
            end
        end
        evq.delete();
    endtask

    initial begin
        int unsigned c0;
        int unsigned lat;
        int          n;
        int          ones;
        logic [8:0]  d;
        logic        pb, s1, s2, exp_brk, exp_perr, exp_ferr;

        rst_n = 1'b0; clr_n = 1'b1; ckdiv = '0; dlen = 4'd8; par_en = 1'b0; par_odd = 1'b0;
        stop2 = 1'b0; totime = '0; rf_full = 1'b0; uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_rf_wbyte", rf_wbyte, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_brk", brk, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        idle_bits(1);

        // 8N1 at one tick per clock; the write must land inside the stop bit
        c0 = cyc;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        lat = (evq.size() > 0) ? evq[0].t - c0 : 0;
        chk("a5_latency_in_stop", (lat >= 9 * OVS + OVS / 2) && (lat <= 10 * OVS), 1);
        expect_ev("a5", K_WR, 9'h0A5, 1'b0, 1'b0);

        ckdiv = 3; dlen = 4'd9; par_en = 1'b1; par_odd = 1'b1;
        idle_bits(1);
        send_frame(9'h1C3, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        expect_ev("par_ok", K_WR, 9'h1C3, 1'b0, 1'b0);
        send_frame(9'h1C3, 9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        expect_ev("par_bad", K_WR, 9'h1C3, 1'b1, 1'b0);

        dlen = 4'd7; par_odd = 1'b0; stop2 = 1'b1;
        send_frame(9'h055, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_bits(2);
        expect_ev("e72_stop2", K_WR, 9'h055, 1'b0, 1'b1);

        dlen = 4'd8; par_en = 1'b0; stop2 = 1'b0;
        uart_rxd = 1'b0;
        repeat (5 * (int'(ckdiv) + 1)) @(negedge clk);
        idle_bits(2);
        chk("glitch_no_event", evq.size(), 0);
        send_frame(9'h000, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        expect_ev("zero_frame", K_WR, 9'h000, 1'b0, 1'b0);

        uart_rxd = 1'b0;
        repeat (20 * bit_clks()) @(negedge clk);
        idle_bits(2);
        expect_ev("break", K_BRK, 9'h000, 1'b0, 1'b0);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        expect_ev("after_brk", K_WR, 9'h03C, 1'b0, 1'b0);

        totime = 8'd4; rf_full = 1'b1;
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rf_full = 1'b0;
        idle_bits(12);
        chk("ovr_to_events", evq.size(), 2);
        if (evq.size() == 2) begin
            chk("ovr_kind", evq[0].kind, K_OVR);
            chk("to_kind", evq[1].kind, K_TO);
            chk("to_delay", evq[1].t - evq[0].t, 4 * OVS * (int'(ckdiv) + 1));
        end
        evq.delete();
        totime = '0;

        for (int i = 0; i < 24; i++) begin
            ckdiv   = DIV_W'($urandom_range(0, 2));
            dlen    = 4'($urandom_range(3, 11));
            par_en  = 1'($urandom_range(0, 1));
            par_odd = 1'($urandom_range(0, 1));
            stop2   = 1'($urandom_range(0, 1));
            n = (int'(dlen) < 5) ? 5 : ((int'(dlen) > 9) ? 9 : int'(dlen));
            d = 9'($urandom) & 9'((1 << n) - 1);
            if ($urandom_range(0, 4) == 0) d = '0;
            ones = $countones(d);
            pb = par_odd ^ 1'(ones % 2);
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            s1 = ($urandom_range(0, 3) != 0);
            s2 = ($urandom_range(0, 3) != 0);
            idle_bits(1);
            send_frame(d, n, par_en, pb, s1, stop2, s2);
            idle_bits(2);
            exp_brk  = (d == '0) && (!par_en || !pb) && !s1;
            exp_perr = par_en && (((ones + int'(pb)) % 2) != int'(par_odd));
            exp_ferr = !s1 || (stop2 && !s2);
            expect_ev($sformatf("rnd%0d", i), exp_brk ? K_BRK : K_WR, d, exp_perr, exp_ferr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
